msf_encoder: RTL and testbench

MSF_ENCODER -- requirements
Module: msf_encoder

---
 rtl/msf_pkg.sv | 50 +++++
 rtl/msf_frame_bits.sv | 35 +++
 rtl/msf_encoder.sv | 112 +++++++++++
 tb/tb_msf_encoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/msf_pkg.sv
// msf_pkg: shared constants, time/date record and minute-increment helper for the MSF encoder
// Holds the per-second slot count, the second positions where each BCD field starts,
// the packed time record (field order = transmission order) and the one-minute increment.
package msf_pkg;
  localparam int SLOTS        = 10;
  localparam int SECS         = 60;
  localparam int SEC_YEAR     = 17;
  localparam int SEC_MONTH    = 25;
  localparam int SEC_DAY      = 30;
  localparam int SEC_DOW      = 36;
  localparam int SEC_HOUR     = 39;
  localparam int SEC_MIN      = 45;
  localparam int SEC_ZERO     = 52;
  localparam int SEC_ONES     = 53;
  localparam int SEC_ONES_END = 58;
  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } msf_time_t;
  // Advances hh:mm by one minute in BCD; 23:59 wraps to 00:00, date and dow untouched.
  function automatic msf_time_t inc_minute(msf_time_t t);
    msf_time_t r;
    r = t;
    if (t.minute_l != 4'd9) r.minute_l = t.minute_l + 4'd1;
    else if (t.minute_h != 3'd5) begin
      r.minute_l = '0;
      r.minute_h = t.minute_h + 3'd1;
    end else begin
      r.minute_l = '0;
      r.minute_h = '0;
      if (t.hour_h == 2'd2 && t.hour_l == 4'd3) begin
        r.hour_h = '0;
        r.hour_l = '0;
      end else if (t.hour_l == 4'd9) begin
        r.hour_h = t.hour_h + 2'd1;
        r.hour_l = '0;
      end else r.hour_l = t.hour_l + 4'd1;
    end
    return r;
  endfunction
endpackage

// File: rtl/msf_frame_bits.sv
// msf_frame_bits: combinational MSF A/B bit lookup for a given second of the frame
// Ports: t_i     - active time/date record
//        sec_i   - second index 0-59
//        bit_a_o - A bit for that second
//        bit_b_o - B bit for that second (odd parities in 54-57, else 0)
module msf_frame_bits
  import msf_pkg::*;
(
  input  msf_time_t  t_i,
  input  logic [5:0] sec_i,
  output logic       bit_a_o,
  output logic       bit_b_o
);
  // Ascending vectors indexed directly by second, so each field lands MSB-first.
  logic [0:SECS-1] a_all, b_all;
  logic par_year, par_date, par_dow, par_time;
  always_comb begin
    a_all = '0;
    a_all[SEC_YEAR:SEC_MONTH-1]     = {t_i.year_h, t_i.year_l};
    a_all[SEC_MONTH:SEC_DAY-1]      = {t_i.month_h, t_i.month_l};
    a_all[SEC_DAY:SEC_DOW-1]        = {t_i.day_h, t_i.day_l};
    a_all[SEC_DOW:SEC_HOUR-1]       = t_i.dow;
    a_all[SEC_HOUR:SEC_MIN-1]       = {t_i.hour_h, t_i.hour_l};
    a_all[SEC_MIN:SEC_ZERO-1]       = {t_i.minute_h, t_i.minute_l};
    a_all[SEC_ONES:SEC_ONES_END]    = '1;
    par_year = ~^a_all[SEC_YEAR:SEC_MONTH-1];
    par_date = ~^a_all[SEC_MONTH:SEC_DOW-1];
    par_dow  = ~^a_all[SEC_DOW:SEC_HOUR-1];
    par_time = ~^a_all[SEC_HOUR:SEC_ZERO-1];
    b_all = '0;
    b_all[SEC_ONES+1:SEC_ONES+4] = {par_year, par_date, par_dow, par_time};
    bit_a_o = a_all[sec_i];
    bit_b_o = b_all[sec_i];
  end
endmodule

// File: rtl/msf_encoder.sv
// msf_encoder: MSF time-signal carrier encoder with 100 ms slot timing
// Ports: clk_i/rst_ni      - clock, synchronous active-low reset
//        enable_i          - transmit frames when high, idle carrier-on when low
//        load_i + *_i      - strobe capturing a BCD time/date into the pending register
//        data_o            - carrier state (1 = on)
//        second_o/minute_o - first-cycle pulses of each second / of second 00
//        second_count_o    - second currently transmitted
module msf_encoder
  import msf_pkg::*;
#(
  parameter int CLK_FREQ = 12500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       load_i,
  input  logic [3:0] year_h_i,
  input  logic [3:0] year_l_i,
  input  logic       month_h_i,
  input  logic [3:0] month_l_i,
  input  logic [1:0] day_h_i,
  input  logic [3:0] day_l_i,
  input  logic [2:0] dow_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] minute_h_i,
  input  logic [3:0] minute_l_i,
  output logic       data_o,
  output logic       second_o,
  output logic       minute_o,
  output logic [5:0] second_count_o
);
  localparam int TICKS = CLK_FREQ / 10;
  localparam int TW = TICKS > 1 ? $clog2(TICKS) : 1;
  logic run_q, run_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] slot_q, slot_d;
  logic [5:0] sec_q, sec_d;
  logic data_q, data_d, second_q, second_d, minute_q, minute_d;
  logic pend_q, pend_d;
  msf_time_t active_q, active_d, pending_q, pending_d, load_t;
  logic tick_wrap, slot_wrap, sec_wrap, first, frame_start, hold, bit_a, bit_b;
  assign load_t = {year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i, dow_i,
                   hour_h_i, hour_l_i, minute_h_i, minute_l_i};
  // Bits are looked up for the position being entered; active_q is already current
  // by second 01 because it updates on the frame-start edge.
  msf_frame_bits u_bits (
    .t_i    (active_q),
    .sec_i  (sec_d),
    .bit_a_o(bit_a),
    .bit_b_o(bit_b)
  );
  always_comb begin
    tick_wrap   = tick_q == TW'(TICKS - 1);
    slot_wrap   = slot_q == 4'(SLOTS - 1);
    sec_wrap    = sec_q == 6'(SECS - 1);
    first       = enable_i && !run_q;
    frame_start = first || (enable_i && tick_wrap && slot_wrap && sec_wrap);
    hold        = !enable_i || !run_q;
    run_d       = enable_i;
    tick_d      = (hold || tick_wrap) ? '0 : tick_q + TW'(1);
    slot_d      = hold ? '0 : tick_wrap ? (slot_wrap ? '0 : slot_q + 4'd1) : slot_q;
    sec_d       = hold ? '0 : (tick_wrap && slot_wrap) ? (sec_wrap ? '0 : sec_q + 6'd1) : sec_q;
    second_d    = enable_i && tick_d == '0 && slot_d == '0;
    minute_d    = second_d && sec_d == '0;
    data_d      = !enable_i ? 1'b1 :
                  sec_d == '0 ? slot_d >= 4'(SLOTS / 2) :
                  slot_d == 4'd0 ? 1'b0 :
                  slot_d == 4'd1 ? ~bit_a :
                  slot_d == 4'd2 ? ~bit_b : 1'b1;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_d      = pend_q;
    // A load coinciding with frame start wins over any pending value.
    if (frame_start) begin
      active_d = load_i ? load_t : pend_q ? pending_q : first ? active_q : inc_minute(active_q);
      pend_d   = 1'b0;
    end else if (load_i) begin
      pending_d = load_t;
      pend_d    = 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q     <= 1'b0;
      tick_q    <= '0;
      slot_q    <= '0;
      sec_q     <= '0;
      data_q    <= 1'b1;
      second_q  <= 1'b0;
      minute_q  <= 1'b0;
      pend_q    <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
    end else begin
      run_q     <= run_d;
      tick_q    <= tick_d;
      slot_q    <= slot_d;
      sec_q     <= sec_d;
      data_q    <= data_d;
      second_q  <= second_d;
      minute_q  <= minute_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end
  assign data_o         = data_q;
  assign second_o       = second_q;
  assign minute_o       = minute_q;
  assign second_count_o = sec_q;
endmodule

// File: tb/tb_msf_encoder.sv
// tb_msf_encoder: self-checking bench for msf_encoder at CLK_FREQ=100 (10 cycles per slot)
module tb_msf_encoder;
  logic clk = 1'b0;
  logic rst_n, enable, load;
  logic [34:0] ld_vec;
  logic [3:0] year_h, year_l, month_l, day_l, hour_l, minute_l;
  logic month_h;
  logic [1:0] day_h, hour_h;
  logic [2:0] dow, minute_h;
  logic data_o, second_o, minute_o;
  logic [5:0] second_count_o;
  int checks = 0;
  int fails = 0;
  typedef struct {int sec; logic s1; logic s2;} exp_t;
  exp_t sb[$];
  assign {year_h, year_l, month_h, month_l, day_h, day_l, dow, hour_h, hour_l, minute_h, minute_l} = ld_vec;
  always #5 clk = ~clk;
  msf_encoder #(.CLK_FREQ(100)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .load_i(load),
    .year_h_i(year_h), .year_l_i(year_l), .month_h_i(month_h), .month_l_i(month_l),
    .day_h_i(day_h), .day_l_i(day_l), .dow_i(dow), .hour_h_i(hour_h), .hour_l_i(hour_l),
    .minute_h_i(minute_h), .minute_l_i(minute_l),
    .data_o(data_o), .second_o(second_o), .minute_o(minute_o), .second_count_o(second_count_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int at, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at=%0d got=%0h exp=%0h", tag, at, got, exp);
    end
  endtask
  function automatic logic [34:0] enc(int yy, int mo, int dd, int dw, int hh, int mi);
    return {4'(yy / 10), 4'(yy % 10), 1'(mo / 10), 4'(mo % 10), 2'(dd / 10), 4'(dd % 10),
            3'(dw), 2'(hh / 10), 4'(hh % 10), 3'(mi / 10), 4'(mi % 10)};
  endfunction
  // Expected slot-1 / slot-2 carrier levels for second s of a frame carrying v.
  task automatic model(input logic [34:0] v, input int s, output logic s1, output logic s2);
    logic [59:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < 35; i++) a[17 + i] = v[34 - i];
    for (int i = 53; i <= 58; i++) a[i] = 1'b1;
    b[54] = ~^v[34:27];
    b[55] = ~^v[26:16];
    b[56] = ~^v[15:13];
    b[57] = ~^v[12:0];
    s1 = (s == 0) ? 1'b0 : ~a[s];
    s2 = (s == 0) ? 1'b0 : ~b[s];
  endtask
  // Entered on cycle 0 of a frame, leaves on cycle 0 of the next; optional loads at cycles la/lb.
  task automatic run_frame(input logic [34:0] ev, input int la, input logic [34:0] va,
                           input int lb, input logic [34:0] vb);
    exp_t e;
    for (int s = 0; s < 60; s++) begin
      e.sec = s;
      model(ev, s, e.s1, e.s2);
      sb.push_back(e);
    end
    for (int c = 0; c < 6000; c++) begin
      int s;
      s = c / 100;
      if (c % 100 == 0) begin
        chk("second_o", c, 32'(second_o), 32'd1);
        chk("minute_o", c, 32'(minute_o), 32'(s == 0));
        chk("second_count", c, 32'(second_count_o), 32'(s));
      end
      if (c % 100 == 1) chk("second_pulse_end", c, 32'(second_o | minute_o), 32'd0);
      if (c % 100 == 5) chk("slot0", c, 32'(data_o), 32'd0);
      if (c == 49) chk("sec00_slot4", c, 32'(data_o), 32'd0);
      if (c == 50) chk("sec00_slot5", c, 32'(data_o), 32'd1);
      if (c % 100 == 95) chk("slot9", c, 32'(data_o), 32'd1);
      if (c % 100 == 15) begin
        e = sb.pop_front();
        chk("sb_sec", c, 32'(s), 32'(e.sec));
        chk("slot1_bitA", c, 32'(data_o), 32'(e.s1));
      end
      if (c % 100 == 25) chk("slot2_bitB", c, 32'(data_o), 32'(e.s2));
      load = (c == la) || (c == lb);
      ld_vec = (c == la) ? va : (c == lb) ? vb : ld_vec;
      tick();
    end
    load = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    ld_vec = '0;
    repeat (3) tick();
    chk("rst_data", 0, 32'(data_o), 32'd1);
    chk("rst_second", 0, 32'(second_o), 32'd0);
    chk("rst_minute", 0, 32'(minute_o), 32'd0);
    chk("rst_count", 0, 32'(second_count_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    ld_vec = enc(23, 3, 14, 2, 12, 34);
    load = 1'b1;
    tick();
    load = 1'b0;
    ld_vec = '0;
    repeat (5) tick();
    chk("idle_data", 0, 32'(data_o), 32'd1);
    chk("idle_pulses", 0, 32'(second_o | minute_o), 32'd0);
    chk("idle_count", 0, 32'(second_count_o), 32'd0);
    enable = 1'b1;
    tick();
    run_frame(enc(23, 3, 14, 2, 12, 34), -1, '0, -1, '0);
    run_frame(enc(23, 3, 14, 2, 12, 35), 1000, enc(23, 3, 14, 2, 22, 22), 2000, enc(23, 3, 14, 2, 23, 59));
    run_frame(enc(23, 3, 14, 2, 23, 59), -1, '0, -1, '0);
    run_frame(enc(23, 3, 14, 2, 0, 0), 3000, enc(23, 3, 14, 2, 10, 0), -1, '0);
    run_frame(enc(23, 3, 14, 2, 10, 0), 5999, enc(24, 12, 31, 6, 7, 45), -1, '0);
    run_frame(enc(24, 12, 31, 6, 7, 45), -1, '0, -1, '0);
    repeat (105) tick();
    chk("pre_abort_count", 105, 32'(second_count_o), 32'd1);
    chk("pre_abort_data", 105, 32'(data_o), 32'd0);
    enable = 1'b0;
    tick();
    chk("abort_data", 0, 32'(data_o), 32'd1);
    chk("abort_count", 0, 32'(second_count_o), 32'd0);
    chk("abort_pulses", 0, 32'(second_o | minute_o), 32'd0);
    tick();
    chk("abort_idle_data", 1, 32'(data_o), 32'd1);
    enable = 1'b1;
    tick();
    run_frame(enc(24, 12, 31, 6, 7, 46), -1, '0, -1, '0);
    repeat (2015) tick();
    chk("pre_rst_count", 2015, 32'(second_count_o), 32'd20);
    rst_n = 1'b0;
    tick();
    chk("midrst_data", 0, 32'(data_o), 32'd1);
    chk("midrst_count", 0, 32'(second_count_o), 32'd0);
    chk("midrst_pulses", 0, 32'(second_o | minute_o), 32'd0);
    rst_n = 1'b1;
    tick();
    run_frame(enc(0, 0, 0, 0, 0, 0), -1, '0, -1, '0);
    chk("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
